// File: rtl/weight_buffer_loader_if.sv
// Serial weight stream and weight-BRAM write port of the weight buffer loader.
// The master modport is the loader side; the slave modport is the host/memory side.
interface weight_buffer_loader_if #(
  parameter int unsigned M    = 8,
  parameter int unsigned TAPS = 18,
  parameter int unsigned AW   = 8
);
  logic                start;
  logic [M-1:0]        in_data;
  logic                in_valid;
  logic                in_ready;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [M*TAPS-1:0]   wr_data;
  logic                busy;
  logic                load_done;

  modport master (
    input  start, in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data, busy, load_done
  );

  modport slave (
    output start, in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data, busy, load_done
  );
endinterface

// File: rtl/weight_buffer_loader.sv
// Packs a serial stream of weights into TAPS-wide filter words and writes
// NUM_FILTERS of them to consecutive weight-memory addresses starting at 0.
module weight_buffer_loader #(
  parameter int unsigned M           = 8,
  parameter int unsigned TAPS        = 18,
  parameter int unsigned NUM_FILTERS = 8,
  parameter int unsigned AW          = 8
) (
  input logic                 clk,
  input logic                 Rst,
  weight_buffer_loader_if.master bus
);

  localparam int unsigned CW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CW-1:0] TapLast  = CW'(TAPS - 1);
  localparam logic [AW-1:0] AddrLast = AW'(NUM_FILTERS - 1);

  typedef enum logic [1:0] {StIdle, StFill, StWrite, StDone} state_e;

  state_e              r_state, w_state_nxt;
  logic [CW-1:0]       r_tap_cnt, w_tap_nxt;
  logic [M*TAPS-1:0]   r_shift, w_shift_nxt;
  logic [AW-1:0]       r_addr, w_addr_nxt;

  always_ff @(posedge clk) begin
    if (Rst) begin
      r_state   <= StIdle;
      r_tap_cnt <= '0;
      r_shift   <= '0;
      r_addr    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_tap_cnt <= w_tap_nxt;
      r_shift   <= w_shift_nxt;
      r_addr    <= w_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tap_nxt   = r_tap_cnt;
    w_shift_nxt = r_shift;
    w_addr_nxt  = r_addr;
    unique case (r_state)
      StIdle, StDone: begin
        if (bus.start) begin
          w_state_nxt = StFill;
          w_tap_nxt   = '0;
          w_shift_nxt = '0;
          w_addr_nxt  = '0;
        end
      end
      StFill: begin
        // First accepted weight migrates up to the W00 slot at the MSB end.
        if (bus.in_valid) begin
          w_shift_nxt = {r_shift[M*(TAPS-1)-1:0], bus.in_data};
          if (r_tap_cnt == TapLast) begin
            w_tap_nxt   = '0;
            w_state_nxt = StWrite;
          end else begin
            w_tap_nxt = r_tap_cnt + CW'(1);
          end
        end
      end
      StWrite: begin
        if (r_addr == AddrLast) begin
          w_state_nxt = StDone;
        end else begin
          w_addr_nxt  = r_addr + AW'(1);
          w_state_nxt = StFill;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign bus.in_ready  = (r_state == StFill);
  assign bus.wr_en     = (r_state == StWrite);
  assign bus.wr_addr   = r_addr;
  assign bus.wr_data   = r_shift;
  assign bus.busy      = (r_state == StFill) || (r_state == StWrite);
  assign bus.load_done = (r_state == StDone);

endmodule

// File: tb/tb_weight_buffer_loader.sv
// Directed bench for weight_buffer_loader: one default instance and one with a
// single filter word, driven on the falling edge and checked with assertions.
module tb_weight_buffer_loader;
  localparam int unsigned M    = 8;
  localparam int unsigned TAPS = 18;
  localparam int unsigned AW   = 8;
  localparam int unsigned W    = M * TAPS;

  logic clk = 1'b0;
  logic Rst = 1'b1;
  always #5 clk = ~clk;

  weight_buffer_loader_if #(.M(M), .TAPS(TAPS), .AW(AW)) if0 ();
  weight_buffer_loader_if #(.M(M), .TAPS(TAPS), .AW(AW)) if1 ();

  weight_buffer_loader #(.M(M), .TAPS(TAPS), .NUM_FILTERS(8), .AW(AW)) u_dut (
    .clk (clk),
    .Rst (Rst),
    .bus (if0)
  );

  weight_buffer_loader #(.M(M), .TAPS(TAPS), .NUM_FILTERS(1), .AW(AW)) u_dut1 (
    .clk (clk),
    .Rst (Rst),
    .bus (if1)
  );

  int vectors = 0;
  int errs    = 0;

  logic [W-1:0] mem0 [8];
  int wcnt0    = 0;
  int wcnt1    = 0;
  int bad_addr = 0;

  always @(posedge clk) begin
    if (if0.wr_en) begin
      if (if0.wr_addr < 8) mem0[if0.wr_addr[2:0]] <= if0.wr_data;
      else bad_addr <= bad_addr + 1;
      wcnt0 <= wcnt0 + 1;
    end
    if (if1.wr_en) begin
      if (if1.wr_addr != '0) bad_addr <= bad_addr + 1;
      wcnt1 <= wcnt1 + 1;
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_word(input int base, input int k);
    logic [W-1:0] w;
    w = '0;
    for (int j = 0; j < TAPS; j++) w = {w[W-M-1:0], M'((base + 18 * k + j) % 256)};
    return w;
  endfunction

  task automatic set_in(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin
      if1.in_valid = v;
      if1.in_data  = d;
    end else begin
      if0.in_valid = v;
      if0.in_data  = d;
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? if1.in_ready : if0.in_ready;
  endfunction

  task automatic start_pulse(input bit sel);
    if (sel) if1.start = 1'b1;
    else     if0.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    if0.start = 1'b0;
  endtask

  // Holds valid with the byte until ready is seen, so a write cycle is a real stall.
  task automatic send_byte(input bit sel, input logic [7:0] d);
    int t;
    t = 0;
    set_in(sel, 1'b1, d);
    while (!rdy(sel) && t < 64) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait_bounded", W'(t < 64), W'(1));
    @(negedge clk);
    set_in(sel, 1'b0, 8'hA5);
  endtask

  task automatic run_load(input bit sel, input int base, input int n, input bit gaps,
                          input int pulse_at);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(5, 0);
        for (int c = 0; c < g; c++) begin
          set_in(sel, 1'b0, 8'($urandom));
          @(negedge clk);
        end
      end
      if (i == pulse_at) start_pulse(sel);
      send_byte(sel, 8'((base + i) % 256));
    end
  endtask

  task automatic check_full(input string tag, input int base, input int b);
    chk({tag, "_last_wr_en"}, W'(if0.wr_en), W'(1));
    chk({tag, "_last_addr"}, W'(if0.wr_addr), W'(7));
    @(negedge clk);
    chk({tag, "_load_done"}, W'(if0.load_done), W'(1));
    chk({tag, "_busy"}, W'(if0.busy), W'(0));
    chk({tag, "_wr_en_off"}, W'(if0.wr_en), W'(0));
    chk({tag, "_writes"}, W'(wcnt0 - b), W'(8));
    for (int k = 0; k < 8; k++) chk($sformatf("%s_word%0d", tag, k), mem0[k], exp_word(base, k));
  endtask

  initial begin
    int b;
    logic [W-1:0] w7;
    if0.start = 1'b0; if0.in_valid = 1'b0; if0.in_data = '0;
    if1.start = 1'b0; if1.in_valid = 1'b0; if1.in_data = '0;

    // Reset held three cycles, then idle with valid toggling and no start.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 2) Rst = 1'b0;
      chk("idle_in_ready", W'(if0.in_ready), W'(0));
      chk("idle_wr_en", W'(if0.wr_en), W'(0));
      chk("idle_load_done", W'(if0.load_done), W'(0));
      chk("idle_busy", W'(if0.busy), W'(0));
      chk("idle_in_ready1", W'(if1.in_ready), W'(0));
      if0.in_valid = ~if0.in_valid;
      if1.in_valid = ~if1.in_valid;
    end
    chk("reset_wr_addr", W'(if0.wr_addr), W'(0));
    chk("reset_wr_data", if0.wr_data, W'(0));
    chk("idle_no_writes", W'(wcnt0 + wcnt1), W'(0));
    if0.in_valid = 1'b0;
    if1.in_valid = 1'b0;

    // Single word packing on the one-filter instance.
    start_pulse(1'b1);
    chk("single_busy", W'(if1.busy), W'(1));
    for (int i = 1; i <= 18; i++) begin
      if (i == 18) chk("single_no_early_write", W'(wcnt1), W'(0));
      send_byte(1'b1, 8'(i));
    end
    chk("single_wr_en", W'(if1.wr_en), W'(1));
    chk("single_wr_addr", W'(if1.wr_addr), W'(0));
    chk("single_msb", W'(if1.wr_data[143:136]), W'(1));
    chk("single_lsb", W'(if1.wr_data[7:0]), W'(18));
    chk("single_word", if1.wr_data, exp_word(1, 0));
    @(negedge clk);
    chk("single_load_done", W'(if1.load_done), W'(1));
    chk("single_wr_en_off", W'(if1.wr_en), W'(0));
    chk("single_busy_off", W'(if1.busy), W'(0));
    chk("single_one_write", W'(wcnt1), W'(1));

    // Full load, back-to-back stream.
    b = wcnt0;
    start_pulse(1'b0);
    run_load(1'b0, 0, 144, 1'b0, -1);
    check_full("full", 0, b);
    w7 = mem0[7];
    chk("full_w7_msb", W'(w7[143:136]), W'(126));
    chk("full_w7_lsb", W'(w7[7:0]), W'(143));

    // Same load with random valid gaps.
    b = wcnt0;
    start_pulse(1'b0);
    chk("stall_done_dropped", W'(if0.load_done), W'(0));
    run_load(1'b0, 0, 144, 1'b1, -1);
    check_full("stall", 0, b);

    // Restart from DONE with new values and a start pulse ignored mid-FILL.
    b = wcnt0;
    start_pulse(1'b0);
    chk("restart_done_low", W'(if0.load_done), W'(0));
    chk("restart_busy", W'(if0.busy), W'(1));
    run_load(1'b0, 200, 80, 1'b1, 25);
    chk("restart_mid_done_low", W'(if0.load_done), W'(0));
    run_load(1'b0, 280, 64, 1'b1, -1);
    check_full("restart", 200, b);

    // Reset after the 10th byte of word 3.
    b = wcnt0;
    start_pulse(1'b0);
    run_load(1'b0, 0, 64, 1'b1, -1);
    chk("midrst_writes_before", W'(wcnt0 - b), W'(3));
    Rst = 1'b1;
    @(negedge clk);
    Rst = 1'b0;
    chk("midrst_in_ready", W'(if0.in_ready), W'(0));
    chk("midrst_wr_en", W'(if0.wr_en), W'(0));
    chk("midrst_wr_addr", W'(if0.wr_addr), W'(0));
    chk("midrst_wr_data", if0.wr_data, W'(0));
    chk("midrst_busy", W'(if0.busy), W'(0));
    chk("midrst_load_done", W'(if0.load_done), W'(0));
    if0.in_valid = 1'b1;
    repeat (30) @(negedge clk);
    if0.in_valid = 1'b0;
    chk("midrst_no_more_writes", W'(wcnt0 - b), W'(3));
    chk("midrst_still_idle", W'(if0.busy), W'(0));

    b = wcnt0;
    start_pulse(1'b0);
    run_load(1'b0, 0, 144, 1'b1, -1);
    check_full("reload", 0, b);

    chk("addr_in_range", W'(bad_addr), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/weight_buffer_loader.md
Name: weight_buffer_loader

Overview:
- Writer side of the weight buffer. The weight-fetch block reads one packed 18-tap filter word per address: two 3x3 kernels, W00..W08 and W10..W18.
- This block accepts a serial stream of M-bit weights over a valid/ready handshake and packs each group of TAPS weights into one word.
- It writes NUM_FILTERS consecutive words to the weight memory write port, starting at address 0, then signals completion.
- It sits between the host/DMA weight source and port A (write) of the weight BRAM.

Parameters:
- M, 8, width of one weight
- TAPS, 18, weights per filter word
- NUM_FILTERS, 8, filter words per load, written to addresses 0..NUM_FILTERS-1
- AW, 8, memory address width

Ports:
- clk  in  1  rising-edge clock
- Rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to begin a load; honoured only in IDLE or DONE
- in_data  in  M  weight value
- in_valid  in  1  in_data is valid
- in_ready  out  1  block accepts in_data this cycle
- wr_en  out  1  memory write strobe, one cycle per word
- wr_addr  out  AW  memory write address
- wr_data  out  M*TAPS  packed filter word
- busy  out  1  high in FILL or WRITE
- load_done  out  1  level; high in DONE

Behaviour:
- Interface: one clock, clk. Reset Rst is synchronous and active-high, sampled only on the rising edge of clk.
- Reset values:
  - state=IDLE; in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, load_done=0.
  - Internal tap counter and shift register cleared.
- Reset mid-operation: any partial word is discarded and no write is issued in the reset cycle or after it. A new start is needed.
- States: IDLE, FILL, WRITE, DONE.
- IDLE:
  - in_ready=0.
  - start -> FILL. On that edge: tap_cnt=0, wr_addr=0, shift register cleared.
- FILL:
  - in_ready=1 combinationally.
  - Transfer occurs when in_valid & in_ready on a rising edge: shift register <= {shift[M*(TAPS-1)-1:0], in_data}, tap_cnt++.
  - When a transfer happens with tap_cnt==TAPS-1 -> WRITE, with tap_cnt reset to 0.
  - in_valid low stalls indefinitely with no state change.
- Packing order: the first weight accepted ends in bits [M*TAPS-1:M*(TAPS-1)] (W00 slot). The last weight accepted ends in bits [M-1:0] (W18 slot).
- WRITE:
  - One cycle. wr_en=1, wr_data=shift register, wr_addr=current filter index. in_ready=0.
  - On exit: if wr_addr==NUM_FILTERS-1 -> DONE, with wr_addr held. Otherwise wr_addr++ -> FILL.
- DONE:
  - load_done=1 and in_ready=0. Held until start.
  - start -> FILL with the same initialisation as from IDLE; load_done drops on that edge.
- start in FILL or WRITE is ignored and has no side effect.
- wr_en is never asserted outside WRITE.
- wr_data and wr_addr are registered and stable while wr_en=1.
- Minimum per-word time: TAPS accept cycles + 1 write cycle. A full load takes at least NUM_FILTERS*(TAPS+1) cycles after start.
- Data values are passed through unmodified; no sign or width conversion.
- Inputs other than start are ignored in IDLE and DONE.

Test Plan:
- Reset then idle: hold Rst for 3 cycles, toggle in_valid with start=0 -> in_ready=0, wr_en=0, load_done=0 throughout.
- Single-word packing (NUM_FILTERS=1): start, then stream 1..18 with in_valid held high -> exactly one wr_en pulse 19 cycles after the first transfer, with:
  - wr_addr=0
  - wr_data[143:136]=1, wr_data[7:0]=18
  - load_done=1 the next cycle.
- Full load (default params): stream 144 bytes, value = index mod 256 -> 8 wr_en pulses at addresses 0..7. Word k MSB byte = 18k and LSB byte = 18k+17. Then load_done=1 and busy=0.
- Backpressure/stall: random in_valid gaps of 0-5 cycles during the full load -> identical memory contents to the previous test. No write occurs in any cycle where in_valid was the only change.
- Ignored start and restart:
  - Pulse start mid-FILL -> tap_cnt and wr_addr unaffected.
  - After DONE, pulse start and load values 200..343 mod 256 -> addresses 0..7 rewritten and load_done low until complete.
- Reset mid-load: assert Rst after the 10th byte of word 3 -> no further wr_en and all outputs return to reset values. A subsequent start and 144-byte load rewrites from address 0 correctly.
